csi_rx_packet_decoder: RTL and testbench

CSI_RX_PACKET_DECODER -- requirements
Module: csi_rx_packet_decoder

---
 rtl/csi_rx_packet_decoder.sv | 218 +++++++++++++++++++++
 tb/tb_csi_rx_packet_decoder.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csi_rx_packet_decoder.sv
// CSI-2 receive packet decoder: turns a lane-merged, sync-stripped byte
// stream into frame start/end events and a RAW14 pixel stream carrying
// first/last-of-line flags, with error pulses for bad headers and cut packets.
//
// Input handshake: a byte on rx_data is consumed on every rising clk edge
// where rx_active and rx_valid are both high. There is no ready signal; the
// decoder always accepts. While rx_active is high and rx_valid is low,
// all state holds. rx_active falling ends the burst.
module csi_rx_packet_decoder #(
  parameter int         IMAGE_PIXEL_WIDTH     = 14,
  parameter logic [1:0] VIRTUAL_CHANNEL       = 2'h0,
  parameter logic [7:0] ECC                   = 8'hCC,
  parameter logic [5:0] PIXEL14BITS_DATA_TYPE = 6'h2D,
  parameter logic [5:0] FRAME_START_DATA_TYPE = 6'h0,
  parameter logic [5:0] FRAME_END_DATA_TYPE   = 6'h1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         rx_active,
  input  logic                         rx_valid,
  input  logic [7:0]                   rx_data,
  output logic                         frame_start,
  output logic                         frame_end,
  output logic [15:0]                  frame_num,
  output logic [7:0]                   line_cnt,
  output logic                         pix_valid,
  output logic [IMAGE_PIXEL_WIDTH-1:0] pix_data,
  output logic                         line_first,
  output logic                         line_last,
  output logic                         ecc_err,
  output logic                         dt_err,
  output logic                         trunc_err,
  output logic [2:0]                   dbg_state
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_HDR     = 3'd1;
  localparam logic [2:0] S_PAYLOAD = 3'd2;
  localparam logic [2:0] S_CRC     = 3'd3;
  localparam logic [2:0] S_DROP    = 3'd4;

  logic [2:0]  r_state;
  logic        r_need_low;   // set by reset: wait for a fresh rx_active period
  logic [7:0]  r_di;
  logic [15:0] r_wc;
  logic [1:0]  r_hdr_idx;
  logic [15:0] r_byte_cnt;   // payload bytes still to come, including current
  logic [2:0]  r_grp_idx;    // position of the next byte inside a 7-byte group
  logic [7:0]  r_grp [0:5];  // first six bytes of the group being collected
  logic        r_first;      // next emitted pixel is the first of the packet
  logic        r_crc_idx;
  logic [13:0] r_buf [0:2];  // P1..P3 waiting to be emitted
  logic [1:0]  r_emit_cnt;
  logic        r_buf_last;   // buffered group is the last complete group

  logic        w_grp_done;
  logic        w_last_grp;
  logic [23:0] w_lsb;
  logic [13:0] w_p0, w_p1, w_p2, w_p3;

  assign dbg_state = r_state;

  // A group completes when its 7th byte is accepted; the low-bit word is
  // bytes 4..6, byte 4 in the least significant position.
  assign w_grp_done = (r_state == S_PAYLOAD) && rx_active && rx_valid && (r_grp_idx == 3'd6);
  assign w_last_grp = (r_byte_cnt < 16'd8);
  assign w_lsb = {rx_data, r_grp[5], r_grp[4]};
  assign w_p0  = {r_grp[0], w_lsb[5:0]};
  assign w_p1  = {r_grp[1], w_lsb[11:6]};
  assign w_p2  = {r_grp[2], w_lsb[17:12]};
  assign w_p3  = {r_grp[3], w_lsb[23:18]};

  // Packet FSM: header parse, payload byte accounting, CRC skip, event pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_need_low  <= 1'b1;
      r_di        <= '0;
      r_wc        <= '0;
      r_hdr_idx   <= '0;
      r_byte_cnt  <= '0;
      r_grp_idx   <= '0;
      r_first     <= 1'b0;
      r_crc_idx   <= 1'b0;
      for (int i = 0; i < 6; i++) r_grp[i] <= '0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      frame_num   <= '0;
      line_cnt    <= '0;
      ecc_err     <= 1'b0;
      dt_err      <= 1'b0;
      trunc_err   <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      ecc_err     <= 1'b0;
      dt_err      <= 1'b0;
      trunc_err   <= 1'b0;
      if (!rx_active) r_need_low <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (rx_active && rx_valid && !r_need_low) begin
            r_di      <= rx_data;
            r_hdr_idx <= 2'd0;
            r_state   <= S_HDR;
          end
        end
        S_HDR: begin
          if (!rx_active) begin
            trunc_err <= 1'b1;
            r_state   <= S_IDLE;
          end else if (rx_valid) begin
            if (r_hdr_idx == 2'd0) begin
              r_wc[7:0] <= rx_data;
              r_hdr_idx <= 2'd1;
            end else if (r_hdr_idx == 2'd1) begin
              r_wc[15:8] <= rx_data;
              r_hdr_idx  <= 2'd2;
            end else if ((r_di[7:6] != VIRTUAL_CHANNEL) || (rx_data != ECC)) begin
              ecc_err <= 1'b1;
              r_state <= S_DROP;
            end else if (r_di[5:0] == FRAME_START_DATA_TYPE) begin
              frame_start <= 1'b1;
              frame_num   <= r_wc;
              line_cnt    <= '0;
              r_state     <= S_DROP;
            end else if (r_di[5:0] == FRAME_END_DATA_TYPE) begin
              frame_end <= 1'b1;
              r_state   <= S_DROP;
            end else if (r_di[5:0] == PIXEL14BITS_DATA_TYPE) begin
              r_crc_idx  <= 1'b0;
              r_byte_cnt <= r_wc;
              r_grp_idx  <= 3'd0;
              r_first    <= 1'b1;
              r_state    <= (r_wc == 16'd0) ? S_CRC : S_PAYLOAD;
            end else begin
              dt_err  <= 1'b1;
              r_state <= S_DROP;
            end
          end
        end
        S_PAYLOAD: begin
          if (!rx_active) begin
            trunc_err <= 1'b1;
            r_state   <= S_IDLE;
          end else if (rx_valid) begin
            r_byte_cnt <= r_byte_cnt - 16'd1;
            if (r_grp_idx == 3'd6) begin
              r_grp_idx <= 3'd0;
              r_first   <= 1'b0;
            end else begin
              r_grp[r_grp_idx] <= rx_data;
              r_grp_idx        <= r_grp_idx + 3'd1;
            end
            if (r_byte_cnt == 16'd1) begin
              // A byte count that is not a multiple of 7 leaves a partial group.
              if (r_grp_idx != 3'd6) trunc_err <= 1'b1;
              r_state <= S_CRC;
            end
          end
        end
        S_CRC: begin
          if (!rx_active) begin
            trunc_err <= 1'b1;
            r_state   <= S_IDLE;
          end else if (rx_valid) begin
            if (r_crc_idx) begin
              line_cnt <= line_cnt + 8'd1;
              r_state  <= S_DROP;
            end else begin
              r_crc_idx <= 1'b1;
            end
          end
        end
        S_DROP: begin
          if (!rx_active) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Emission pipe: P0 goes out the cycle after a group completes, P1..P3 follow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_valid  <= 1'b0;
      pix_data   <= '0;
      line_first <= 1'b0;
      line_last  <= 1'b0;
      r_emit_cnt <= '0;
      r_buf_last <= 1'b0;
      for (int i = 0; i < 3; i++) r_buf[i] <= '0;
    end else if (w_grp_done) begin
      pix_valid  <= 1'b1;
      pix_data   <= IMAGE_PIXEL_WIDTH'(w_p0);
      line_first <= r_first;
      line_last  <= 1'b0;
      r_buf[0]   <= w_p1;
      r_buf[1]   <= w_p2;
      r_buf[2]   <= w_p3;
      r_emit_cnt <= 2'd3;
      r_buf_last <= w_last_grp;
    end else if (r_emit_cnt != 2'd0) begin
      pix_valid  <= 1'b1;
      pix_data   <= IMAGE_PIXEL_WIDTH'(r_buf[0]);
      line_first <= 1'b0;
      line_last  <= r_buf_last && (r_emit_cnt == 2'd1);
      r_buf[0]   <= r_buf[1];
      r_buf[1]   <= r_buf[2];
      r_emit_cnt <= r_emit_cnt - 2'd1;
    end else begin
      pix_valid  <= 1'b0;
      line_first <= 1'b0;
      line_last  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_csi_rx_packet_decoder.sv
// Bench for csi_rx_packet_decoder: directed and randomized bursts, each
// checked against a packet-level reference model of the decoder.
module tb_csi_rx_packet_decoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx_active;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        frame_start, frame_end;
  logic [15:0] frame_num;
  logic [7:0]  line_cnt;
  logic        pix_valid;
  logic [13:0] pix_data;
  logic        line_first, line_last;
  logic        ecc_err, dt_err, trunc_err;
  logic [2:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  logic [7:0]  burst_q[$];
  logic [15:0] exp_q[$];   // {line_first, line_last, pixel[13:0]}
  logic [15:0] obs_q[$];
  int exp_fs, exp_fe, exp_ecc, exp_dt, exp_trunc;
  int cnt_fs, cnt_fe, cnt_ecc, cnt_dt, cnt_trunc;
  logic [15:0] exp_frame_num;
  logic [7:0]  exp_line_cnt;
  int run_len = 0;

  csi_rx_packet_decoder dut (
    .clk(clk), .rst_n(rst_n), .rx_active(rx_active), .rx_valid(rx_valid),
    .rx_data(rx_data), .frame_start(frame_start), .frame_end(frame_end),
    .frame_num(frame_num), .line_cnt(line_cnt), .pix_valid(pix_valid),
    .pix_data(pix_data), .line_first(line_first), .line_last(line_last),
    .ecc_err(ecc_err), .dt_err(dt_err), .trunc_err(trunc_err),
    .dbg_state(dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // monitor: count pulses, collect pixels, check each emission run is 4 long
  always @(negedge clk) begin
    if (!rst_n) begin
      run_len = 0;
    end else begin
      if (frame_start) cnt_fs++;
      if (frame_end)   cnt_fe++;
      if (ecc_err)     cnt_ecc++;
      if (dt_err)      cnt_dt++;
      if (trunc_err)   cnt_trunc++;
      if (pix_valid) begin
        obs_q.push_back({line_first, line_last, pix_data});
        run_len++;
      end else if (run_len != 0) begin
        check("pix_run_len", run_len, 4);
        run_len = 0;
      end
    end
  end

  // driver tasks
  task automatic idle_cycle();
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
    @(posedge clk); #1;
  endtask

  task automatic drive_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic push_hdr(input logic [7:0] di, input logic [15:0] wc, input logic [7:0] ecc);
    burst_q.push_back(di);
    burst_q.push_back(wc[7:0]);
    burst_q.push_back(wc[15:8]);
    burst_q.push_back(ecc);
  endtask

  task automatic push_rand(input int n);
    for (int i = 0; i < n; i++) burst_q.push_back(8'($urandom));
  endtask

  // reference model: outcome of one whole burst from the packet rules
  task automatic model_burst();
    int n, wc, avail, groups;
    logic [7:0] di;
    n = burst_q.size();
    exp_q.delete();
    exp_fs = 0; exp_fe = 0; exp_ecc = 0; exp_dt = 0; exp_trunc = 0;
    if (n < 4) begin
      exp_trunc = 1;
      return;
    end
    di = burst_q[0];
    wc = int'(burst_q[1]) + 256 * int'(burst_q[2]);
    if (di[7:6] != 2'h0 || burst_q[3] != 8'hCC) begin
      exp_ecc = 1;
    end else if (di[5:0] == 6'h00) begin
      exp_fs = 1;
      exp_frame_num = 16'(wc);
      exp_line_cnt = 8'd0;
    end else if (di[5:0] == 6'h01) begin
      exp_fe = 1;
    end else if (di[5:0] == 6'h2D) begin
      avail  = n - 4;
      groups = wc / 7;
      for (int g = 0; g < groups; g++) begin
        int base, lsb, pix;
        int bv[7];
        base = 4 + 7 * g;
        if (base + 7 <= n) begin
          for (int k = 0; k < 7; k++) bv[k] = int'(burst_q[base + k]);
          lsb = bv[4] + 256 * bv[5] + 65536 * bv[6];
          for (int i = 0; i < 4; i++) begin
            logic f, l;
            pix = bv[i] * 64 + ((lsb >> (6 * i)) % 64);
            f = (g == 0 && i == 0);
            l = (g == groups - 1 && i == 3);
            exp_q.push_back({f, l, 14'(pix)});
          end
        end
      end
      if (avail < wc) begin
        exp_trunc = 1;
      end else begin
        if (wc % 7 != 0) exp_trunc++;
        if (avail - wc >= 2) exp_line_cnt = exp_line_cnt + 8'd1;
        else exp_trunc++;
      end
    end else begin
      exp_dt = 1;
    end
  endtask

  // scoreboard: drive burst_q as one rx_active period and compare with model
  task automatic run_burst(input int gap_mode);
    int n;
    model_burst();
    n = burst_q.size();
    cnt_fs = 0; cnt_fe = 0; cnt_ecc = 0; cnt_dt = 0; cnt_trunc = 0;
    obs_q.delete();
    rx_active = 1'b1;
    for (int i = 0; i < n; i++) begin
      int gaps;
      gaps = (gap_mode == 1) ? 1 : (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
      repeat (gaps) idle_cycle();
      drive_byte(burst_q[i]);
      if (i == 3) begin
        check("hdr_frame_start", 32'(frame_start), exp_fs);
        check("hdr_frame_end", 32'(frame_end), exp_fe);
        check("hdr_ecc_err", 32'(ecc_err), exp_ecc);
        check("hdr_dt_err", 32'(dt_err), exp_dt);
        check("hdr_frame_num", 32'(frame_num), 32'(exp_frame_num));
      end
      if (i == 10 && exp_q.size() > 0) begin
        check("lat_pix_valid", 32'(pix_valid), 1);
        check("lat_pix_data", 32'(pix_data), 32'(exp_q[0][13:0]));
        check("lat_line_first", 32'(line_first), 1);
      end
    end
    rx_active = 1'b0;
    rx_valid  = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("cnt_frame_start", cnt_fs, exp_fs);
    check("cnt_frame_end", cnt_fe, exp_fe);
    check("cnt_ecc_err", cnt_ecc, exp_ecc);
    check("cnt_dt_err", cnt_dt, exp_dt);
    check("cnt_trunc_err", cnt_trunc, exp_trunc);
    check("pix_count", obs_q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++)
      check("pixel", 32'(obs_q[k]), 32'(exp_q[k]));
    check("frame_num", 32'(frame_num), 32'(exp_frame_num));
    check("line_cnt", 32'(line_cnt), 32'(exp_line_cnt));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pix_valid"}, 32'(pix_valid), 0);
    check({tag, "_pix_data"}, 32'(pix_data), 0);
    check({tag, "_line_first"}, 32'(line_first), 0);
    check({tag, "_line_last"}, 32'(line_last), 0);
    check({tag, "_frame_start"}, 32'(frame_start), 0);
    check({tag, "_frame_end"}, 32'(frame_end), 0);
    check({tag, "_frame_num"}, 32'(frame_num), 0);
    check({tag, "_line_cnt"}, 32'(line_cnt), 0);
    check({tag, "_ecc_err"}, 32'(ecc_err), 0);
    check({tag, "_dt_err"}, 32'(dt_err), 0);
    check({tag, "_trunc_err"}, 32'(trunc_err), 0);
  endtask

  // directed steps
  initial begin
    rst_n = 1'b0; rx_active = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    exp_frame_num = 16'h0000; exp_line_cnt = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // frame start short packet
    burst_q.delete();
    push_hdr(8'h00, 16'h0005, 8'hCC);
    run_burst(0);

    // full RAW14 line, 64 pixels, first group from the known example
    burst_q.delete();
    push_hdr(8'h2D, 16'h0070, 8'hCC);
    burst_q.push_back(8'hFF); burst_q.push_back(8'h00); burst_q.push_back(8'h00);
    burst_q.push_back(8'h00); burst_q.push_back(8'h3F); burst_q.push_back(8'h00);
    burst_q.push_back(8'h00);
    push_rand(105 + 2);
    run_burst(0);
    check("example_p0", 32'(obs_q[0]), 32'({2'b10, 14'h3FFF}));
    check("example_p1", 32'(obs_q[1]), 0);
    check("line_pixels_64", obs_q.size(), 64);

    // same line with a gap on every other cycle
    run_burst(1);

    // bad ECC byte, rest of burst ignored
    burst_q.delete();
    push_hdr(8'h2D, 16'h0070, 8'hAB);
    push_hdr(8'h00, 16'h0009, 8'hCC);
    push_rand(20);
    run_burst(2);

    // wrong virtual channel, unknown data type, frame end
    burst_q.delete(); push_hdr(8'h6D, 16'h000E, 8'hCC); push_rand(16); run_burst(0);
    burst_q.delete(); push_hdr(8'h12, 16'h000E, 8'hCC); push_rand(16); run_burst(0);
    burst_q.delete(); push_hdr(8'h01, 16'h0005, 8'hCC); push_rand(3);  run_burst(0);

    // burst cut after 10 payload bytes, then a clean line
    burst_q.delete(); push_hdr(8'h2D, 16'h0070, 8'hCC); push_rand(10); run_burst(0);
    check("abort_pixels", obs_q.size(), 4);
    burst_q.delete(); push_hdr(8'h2D, 16'h000E, 8'hCC); push_rand(16); run_burst(0);

    // word count not a multiple of 7: partial group dropped
    burst_q.delete(); push_hdr(8'h2D, 16'h000A, 8'hCC); push_rand(12); run_burst(2);

    // randomized bursts of every kind
    for (int r = 0; r < 40; r++) begin
      int kind, wc;
      logic [5:0] dt;
      kind = int'($urandom_range(0, 6));
      wc   = int'($urandom_range(0, 40));
      burst_q.delete();
      case (kind)
        0: begin push_hdr(8'h00, 16'($urandom), 8'hCC); push_rand(int'($urandom_range(0, 3))); end
        1: begin push_hdr(8'h01, 16'($urandom), 8'hCC); push_rand(int'($urandom_range(0, 3))); end
        2: begin
          push_hdr(8'h2D, 16'(wc), 8'hCC);
          if ($urandom_range(0, 3) == 0) push_rand(int'($urandom_range(0, wc + 1)));
          else push_rand(wc + 2 + int'($urandom_range(0, 3)));
        end
        3: begin push_hdr(8'h2D, 16'(wc), 8'hCC ^ 8'($urandom_range(1, 255))); push_rand(wc + 2); end
        4: begin push_hdr({2'($urandom_range(1, 3)), 6'h2D}, 16'(wc), 8'hCC); push_rand(wc + 2); end
        5: begin
          dt = 6'($urandom_range(2, 63));
          if (dt == 6'h2D) dt = 6'h2E;
          push_hdr({2'b00, dt}, 16'(wc), 8'hCC);
          push_rand(wc + 2);
        end
        default: push_rand(int'($urandom_range(1, 3)));
      endcase
      run_burst(2);
    end

    // line counter wraps 255 -> 0
    burst_q.delete(); push_hdr(8'h00, 16'h0100, 8'hCC); run_burst(0);
    for (int i = 0; i < 256; i++) begin
      burst_q.delete(); push_hdr(8'h2D, 16'h0000, 8'hCC); push_rand(2); run_burst(0);
    end
    check("line_cnt_wrap", 32'(line_cnt), 0);

    // reset in the middle of a payload, first group already emitting
    burst_q.delete(); push_hdr(8'h2D, 16'h0070, 8'hCC); push_rand(9);
    cnt_ecc = 0; cnt_dt = 0; cnt_trunc = 0;
    rx_active = 1'b1;
    foreach (burst_q[i]) drive_byte(burst_q[i]);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    check("midreset_no_err", cnt_ecc + cnt_dt + cnt_trunc, 0);
    exp_frame_num = 16'h0000; exp_line_cnt = 8'h00;
    @(posedge clk); #1;
    rst_n = 1'b1;
    cnt_fs = 0; cnt_ecc = 0; cnt_dt = 0; cnt_trunc = 0;
    obs_q.delete();
    // still inside the interrupted burst: a valid-looking header is ignored
    drive_byte(8'h00); drive_byte(8'h07); drive_byte(8'h00); drive_byte(8'hCC);
    rx_active = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("post_reset_fs", cnt_fs, 0);
    check("post_reset_err", cnt_ecc + cnt_dt + cnt_trunc, 0);
    check("post_reset_pix", obs_q.size(), 0);
    check("post_reset_frame_num", 32'(frame_num), 0);
    burst_q.delete(); push_hdr(8'h00, 16'h1234, 8'hCC); run_burst(0);
    burst_q.delete(); push_hdr(8'h2D, 16'h001C, 8'hCC); push_rand(30); run_burst(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
